// File: rtl/tdm_fir_bank.sv
`default_nettype none
// ============================================================================
// tdm_fir_bank : CH-channel x TAPS-tap FIR sharing one signed MAC per strobe.
// Optional macro FILT_SAT_EN: saturating output narrowing plus sticky sat_flag.
// Revision: 1.0
// ============================================================================
module tdm_fir_bank #(
  parameter int N    = 16,
  parameter int TAPS = 4,
  parameter int CH   = 2,
  parameter int ACCW = 2*N + $clog2(TAPS) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [CH*N-1:0]      x_in,
  input  logic                 coef_we,
  input  logic [((CH*TAPS > 1) ? $clog2(CH*TAPS) : 1)-1:0] coef_addr,
  input  logic [N-1:0]         coef_data,
  output logic [CH*N-1:0]      y_out,
  output logic                 y_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic                 sat_flag
);

  localparam int NC = CH * TAPS;
  localparam int AW = (NC > 1) ? $clog2(NC) : 1;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_STORE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [N-1:0]    coef [NC];
  logic signed [N-1:0]    dly  [CH][TAPS];
  logic signed [ACCW-1:0] acc;
  logic [CW-1:0]          ch;
  logic [TW-1:0]          tap;
  logic                   last_tap;
  logic                   last_ch;
  logic                   addr_ok;
  logic [AW-1:0]          coef_idx;
  logic signed [N-1:0]    coef_sel;
  logic signed [N-1:0]    dly_sel;
  logic signed [2*N-1:0]  prod;
  logic [N-1:0]           narrowed;

  assign last_tap = (tap == TW'(TAPS - 1));
  assign last_ch  = (ch == CW'(CH - 1));
  assign busy     = (state != S_IDLE);

  assign coef_idx = AW'(ch) * AW'(TAPS) + AW'(tap);
  assign coef_sel = coef[coef_idx];
  assign dly_sel  = dly[ch][tap];
  assign prod     = coef_sel * dly_sel;

  generate
    if (NC == (1 << AW)) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_part
      assign addr_ok = (coef_addr < AW'(NC));
    end
  endgenerate

`ifdef FILT_SAT_EN
  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = {{(ACCW-N+1){1'b1}}, {(N-1){1'b0}}};

  logic signed [ACCW-1:0] shifted;
  logic                   clamp;

  assign shifted = acc >>> (N - 1);

  always_comb begin
    clamp    = 1'b0;
    narrowed = shifted[N-1:0];
    if (shifted > MAXV) begin
      clamp    = 1'b1;
      narrowed = {1'b0, {(N-1){1'b1}}};
    end else if (shifted < MINV) begin
      clamp    = 1'b1;
      narrowed = {1'b1, {(N-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (state == S_STORE && clamp) begin
      sat_flag <= 1'b1;
    end
  end
`else
  // Wrap-around narrowing: the low N bits of (acc >>> (N-1)).
  assign narrowed = acc[N-1 +: N];
  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (en) state_nxt = S_MAC;
      S_MAC:   if (last_tap) state_nxt = S_STORE;
      S_STORE: state_nxt = last_ch ? S_IDLE : S_MAC;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NC; i++) coef[i] <= '0;
      for (int c = 0; c < CH; c++) begin
        for (int t = 0; t < TAPS; t++) dly[c][t] <= '0;
      end
      acc     <= '0;
      ch      <= '0;
      tap     <= '0;
      y_out   <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      if (coef_we && addr_ok) coef[coef_addr] <= coef_data;
      // Strobes landing mid-round (STORE included) are dropped and flagged.
      if (en && busy) overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (en) begin
            for (int c = 0; c < CH; c++) begin
              dly[c][0] <= x_in[c*N +: N];
              for (int t = 1; t < TAPS; t++) dly[c][t] <= dly[c][t-1];
            end
            ch  <= '0;
            tap <= '0;
            acc <= '0;
          end
        end
        S_MAC: begin
          acc <= acc + {{(ACCW-2*N){prod[2*N-1]}}, prod};
          if (!last_tap) tap <= tap + TW'(1);
        end
        S_STORE: begin
          y_out[ch*N +: N] <= narrowed;
          acc <= '0;
          tap <= '0;
          if (last_ch) y_valid <= 1'b1;
          else         ch      <= ch + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tdm_fir_bank.sv
`default_nettype none
// ============================================================================
// tb_tdm_fir_bank : directed scoreboard bench for tdm_fir_bank (N=16,TAPS=4,CH=2).
// Revision: 1.0
// ============================================================================
module tb_tdm_fir_bank;

  localparam int N    = 16;
  localparam int TAPS = 4;
  localparam int CH   = 2;

`ifdef FILT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [31:0]   x_in = '0;
  logic          coef_we = 1'b0;
  logic [2:0]    coef_addr = '0;
  logic [15:0]   coef_data = '0;
  logic [31:0]   y_out;
  logic          y_valid;
  logic          busy;
  logic          overrun;
  logic          sat_flag;

  typedef struct packed {
    logic [31:0] y;
    logic        sat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  tdm_fir_bank #(.N(N), .TAPS(TAPS), .CH(CH)) dut (
    .clk(clk), .rst(rst), .en(en), .x_in(x_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .y_out(y_out), .y_valid(y_valid), .busy(busy),
    .overrun(overrun), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every y_valid pops one expected result.
  always @(negedge clk) begin
    if (!rst && y_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_y_valid: got y_out %h, required no output", y_out);
      end else begin
        mon_e = sb.pop_front();
        check("y_out", y_out, mon_e.y);
        check("sat_flag", 32'(sat_flag), 32'(mon_e.sat));
      end
    end
  end

  task automatic push(input logic [31:0] y, input logic s);
    exp_t e;
    e.y   = y;
    e.sat = s;
    sb.push_back(e);
  endtask

  task automatic wcoef(input int addr, input logic [15:0] d);
    coef_we   = 1'b1;
    coef_addr = 3'(addr);
    coef_data = d;
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!y_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!y_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: got no y_valid in 40 cycles, required y_valid", name);
    end
    @(negedge clk);
  endtask

  task automatic strobe(input logic [15:0] x0, input logic [15:0] x1,
                        input logic [31:0] ey, input logic es);
    en   = 1'b1;
    x_in = {x1, x0};
    push(ey, es);
    @(negedge clk);
    en   = 1'b0;
    x_in = '0;
    wait_valid("strobe");
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic scenario_impulse;
    wcoef(0, 16'h4000);
    wcoef(1, 16'h2000);
    wcoef(2, 16'h1000);
    wcoef(3, 16'h0800);
    strobe(16'h4000, 16'h0, 32'h0000_2000, 1'b0);
    strobe(16'h0000, 16'h0, 32'h0000_1000, 1'b0);
    strobe(16'h0000, 16'h0, 32'h0000_0800, 1'b0);
    strobe(16'h0000, 16'h0, 32'h0000_0400, 1'b0);
    strobe(16'h0000, 16'h0, 32'h0000_0000, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb;
    int nval;
    @(negedge clk);
    @(negedge clk);
    check("rst_y_out", y_out, 32'h0);
    check("rst_y_valid", 32'(y_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_sat_flag", 32'(sat_flag), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Impulse response through a halving tap set; ch1 has zero coefficients.
    scenario_impulse();

    // Latency: busy for 10 cycles, y_valid in cycle 11, back-to-back accept.
    en   = 1'b1;
    x_in = {16'h0, 16'h4000};
    push(32'h0000_2000, 1'b0);
    @(negedge clk);
    en   = 1'b0;
    x_in = '0;
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(nb), 32'd10);
    check("y_valid_cycle11", 32'(y_valid), 32'h1);
    en = 1'b1;
    push(32'h0000_1000, 1'b0);
    @(negedge clk);
    en = 1'b0;
    check("y_valid_pulse_width", 32'(y_valid), 32'h0);
    check("busy_after_accept", 32'(busy), 32'h1);
    check("overrun_back_to_back", 32'(overrun), 32'h0);
    wait_valid("back_to_back");

    // Overrun: second strobe three cycles in is dropped.
    en = 1'b1;
    push(32'h0000_0800, 1'b0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    en   = 1'b1;
    x_in = {16'h0, 16'h7FFF};
    @(negedge clk);
    en   = 1'b0;
    x_in = '0;
    check("overrun_set", 32'(overrun), 32'h1);
    wait_valid("overrun_round");
    strobe(16'h0, 16'h0, 32'h0000_0400, 1'b0);
    check("overrun_sticky", 32'(overrun), 32'h1);

    // Coefficient of -1.0 on ch1 tap 0.
    wcoef(4, 16'h8000);
    strobe(16'h0, 16'h4000, 32'hC000_0000, 1'b0);

    // Saturation with full-scale coefficients and samples.
    do_reset();
    for (int i = 0; i < 8; i++) wcoef(i, 16'h7FFF);
    strobe(16'h7FFF, 16'h7FFF, 32'h7FFE_7FFE, 1'b0);
    strobe(16'h7FFF, 16'h7FFF, SAT ? 32'h7FFF_7FFF : 32'hFFFC_FFFC, SAT);
    strobe(16'h7FFF, 16'h7FFF, SAT ? 32'h7FFF_7FFF : 32'h7FFA_7FFA, SAT);
    strobe(16'h7FFF, 16'h7FFF, SAT ? 32'h7FFF_7FFF : 32'hFFF8_FFF8, SAT);

    // Asynchronous reset four cycles into a round.
    en   = 1'b1;
    x_in = {16'h0, 16'h4000};
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en   = 1'b0;
    x_in = '0;
    check("overrun_before_reset", 32'(overrun), 32'h1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_y_out", y_out, 32'h0);
    check("async_rst_overrun", 32'(overrun), 32'h0);
    check("async_rst_sat_flag", 32'(sat_flag), 32'h0);
    check("async_rst_y_valid", 32'(y_valid), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    nval = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (y_valid) nval++;
    end
    check("no_y_valid_after_abort", 32'(nval), 32'h0);
    check("idle_after_abort", 32'(busy), 32'h0);
    scenario_impulse();

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
